// File: rtl/rf_alu_sequencer.sv
// rf_alu_sequencer
// Issues one micro-op at a time against the 8x4 register file: reads two
// operands, runs them through a small ALU and writes the result back.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | waiting for START; DONE pulses here for one cycle after WRITE
//   S_READ  | RP/RQ point at the latched sources; operands captured at end
//   S_EXEC  | ALU evaluates; result, write address and flags captured
//   S_WRITE | WR asserted for this single cycle; file captures at its end
module rf_alu_sequencer #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 3
) (
   input  logic              CLK,
   input  logic              CLRN,
   input  logic              START,
   input  logic [1:0]        OP,
   input  logic [ADDR_W-1:0] SRC_P,
   input  logic [ADDR_W-1:0] SRC_Q,
   input  logic [ADDR_W-1:0] DST,
   input  logic [DATA_W-1:0] IMM,
   input  logic [DATA_W-1:0] DATAP,
   input  logic [DATA_W-1:0] DATAQ,
   output logic [ADDR_W-1:0] RP,
   output logic [ADDR_W-1:0] RQ,
   output logic [ADDR_W-1:0] WA,
   output logic              WR,
   output logic [DATA_W-1:0] LD_DATA,
   output logic              BUSY,
   output logic              DONE,
   output logic              CARRY,
   output logic              ZERO
);

   localparam logic [1:0] OP_ADD   = 2'b00;
   localparam logic [1:0] OP_SUB   = 2'b01;
   localparam logic [1:0] OP_AND   = 2'b10;
   localparam logic [1:0] OP_LOADI = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_READ  = 2'b01,
      S_EXEC  = 2'b10,
      S_WRITE = 2'b11
   } state_t;

   state_t state, state_nxt;

   logic              accept;
   logic [1:0]        op_q;
   logic [ADDR_W-1:0] rp_q;
   logic [ADDR_W-1:0] rq_q;
   logic [ADDR_W-1:0] dst_q;
   logic [DATA_W-1:0] imm_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [ADDR_W-1:0] wa_q;
   logic [DATA_W-1:0] ld_q;
   logic              carry_q;
   logic              zero_q;
   logic              done_q;

   logic [DATA_W:0]   sum;
   logic [DATA_W:0]   diff;
   logic [DATA_W-1:0] alu_r;
   logic              alu_c;

   // State register; reset returns to IDLE, which drops WR immediately.
   always_ff @(posedge CLK or negedge CLRN) begin
      if (!CLRN) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and handshake outputs; START is only looked at in IDLE.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      BUSY      = 1'b0;
      WR        = 1'b0;
      case (state)
         S_IDLE: begin
            if (START) begin
               accept    = 1'b1;
               state_nxt = S_READ;
            end
         end
         S_READ: begin
            BUSY      = 1'b1;
            state_nxt = S_EXEC;
         end
         S_EXEC: begin
            BUSY      = 1'b1;
            state_nxt = S_WRITE;
         end
         S_WRITE: begin
            BUSY      = 1'b1;
            WR        = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // ALU; the extra top bit of the subtract is the borrow, so CARRY = no-borrow.
   always_comb begin
      sum   = {1'b0, a_q} + {1'b0, b_q};
      diff  = {1'b0, a_q} - {1'b0, b_q};
      alu_r = '0;
      alu_c = carry_q;
      case (op_q)
         OP_ADD: begin
            alu_r = sum[DATA_W-1:0];
            alu_c = sum[DATA_W];
         end
         OP_SUB: begin
            alu_r = diff[DATA_W-1:0];
            alu_c = ~diff[DATA_W];
         end
         OP_AND:   alu_r = a_q & b_q;
         OP_LOADI: alu_r = imm_q;
         default:  alu_r = '0;
      endcase
   end

   // Command latch; read addresses are loaded here so they are stable throughout READ.
   always_ff @(posedge CLK or negedge CLRN) begin
      if (!CLRN) begin
         op_q  <= '0;
         rp_q  <= '0;
         rq_q  <= '0;
         dst_q <= '0;
         imm_q <= '0;
      end else if (accept) begin
         op_q  <= OP;
         rp_q  <= SRC_P;
         rq_q  <= SRC_Q;
         dst_q <= DST;
         imm_q <= IMM;
      end
   end

   // Operand capture from the combinational register file read ports.
   always_ff @(posedge CLK or negedge CLRN) begin
      if (!CLRN) begin
         a_q <= '0;
         b_q <= '0;
      end else if (state == S_READ) begin
         a_q <= DATAP;
         b_q <= DATAQ;
      end
   end

   // Result, write address and flags update together at the end of EXEC and then hold.
   always_ff @(posedge CLK or negedge CLRN) begin
      if (!CLRN) begin
         wa_q    <= '0;
         ld_q    <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
      end else if (state == S_EXEC) begin
         wa_q    <= dst_q;
         ld_q    <= alu_r;
         carry_q <= alu_c;
         zero_q  <= (alu_r == '0);
      end
   end

   // DONE follows a completed WRITE by one cycle; a reset during WRITE suppresses it.
   always_ff @(posedge CLK or negedge CLRN) begin
      if (!CLRN) begin
         done_q <= 1'b0;
      end else begin
         done_q <= (state == S_WRITE);
      end
   end

   assign RP      = rp_q;
   assign RQ      = rq_q;
   assign WA      = wa_q;
   assign LD_DATA = ld_q;
   assign DONE    = done_q;
   assign CARRY   = carry_q;
   assign ZERO    = zero_q;

endmodule
